cpu7_ifu_iss_ctl: RTL and testbench
===================================

CPU7_IFU_ISS_CTL -- requirements
Module: cpu7_ifu_iss_ctl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: is_valid  in  1  decoded instruction present at issue.
REQ-004 SHALL have ports: is_rs1/is_rs2  in  5 each  source register numbers; is_rs1_en/is_rs2_en  in  1 each  source-read enables.
REQ-005 SHALL have ports: is_rf_wen  in  1, is_rf_target  in  5  destination write enable and register.
REQ-006 SHALL have ports: is_long  in  1  long-latency op (load/mul/div); is_serial  in  1  serializing op (CSR/syscall/break/ertn).
REQ-007 SHALL have ports: ex_ready  in  1  execute accepts this cycle; flush  in  1  exception/branch cancel.
REQ-008 SHALL have ports: wb_valid  in  1, wb_rf_target  in  5  long-latency writeback return; ser_done  in  1  serializing op retired.
REQ-009 SHALL have ports: iss_fire  out  1; de_stall  out  1; sb_busy  out  32; inflight_cnt  out  3; ctl_state  out  2.
REQ-010 SHALL have parameter: IFLT_MAX, default 4, maximum outstanding long-latency ops.

Function
REQ-011 SHALL compute hazard = (rsN_en && rsN!=0 && sb_busy[rsN]) for either source, OR (is_rf_wen && target!=0 && sb_busy[target]) (WAW).
REQ-012 SHALL compute iss_fire combinationally = is_valid && ex_ready && !flush && !hazard && state-permit && !(is_long && inflight_cnt==IFLT_MAX); zero latency.
REQ-013 SHALL drive de_stall = is_valid && !iss_fire && !flush.
REQ-014 SHALL set sb_busy[target] at the clock edge after iss_fire when is_long && is_rf_wen && target!=0; short ops never set bits.
REQ-015 SHALL clear sb_busy[wb_rf_target] on wb_valid; simultaneous set and clear of the same bit: set wins.
REQ-016 SHALL hold sb_busy[0] at 0 permanently.
REQ-017 SHALL increment inflight_cnt on iss_fire && is_long and decrement on wb_valid; both in the same cycle: unchanged.
REQ-018 SHALL ignore wb_valid decrement when inflight_cnt==0 (no underflow); count never exceeds IFLT_MAX.
REQ-019 SHALL implement FSM states RUN=0, DRAIN=1, HOLD=2 on ctl_state.
REQ-020 SHALL in RUN: permit non-serial issue; serial instruction with inflight_cnt!=0 -> DRAIN with no fire; serial instruction with inflight_cnt==0 fires and -> HOLD.
REQ-021 SHALL in DRAIN: permit nothing until inflight_cnt==0, then fire the serial instruction (if ex_ready) and -> HOLD.
REQ-022 SHALL in HOLD: permit no issue; -> RUN on ser_done.
REQ-023 SHALL on flush: suppress iss_fire that cycle and force state -> RUN from any state; flush SHALL NOT modify sb_busy or inflight_cnt (in-flight ops still return).
REQ-024 SHALL give flush priority over ser_done and over any issue in the same cycle.
REQ-025 SHALL not depend on ex_ready for state transitions other than issue.

Reset
REQ-026 SHALL on rst asynchronously clear sb_busy=0, inflight_cnt=0, ctl_state=RUN; iss_fire/de_stall then follow inputs combinationally.
REQ-027 SHALL treat rst asserted mid-DRAIN/HOLD identically: immediate return to RUN, no pending state retained.

Structure
REQ-028 SHALL place state encodings (RUN/DRAIN/HOLD) and IFLT_MAX default in shared package cpu7_iss_pkg.
REQ-029 SHALL implement scoreboard (sb_busy set/clear, hazard lookup) as sub-module cpu7_iss_sb.

Verification
REQ-030 SHALL cover: long op writing r5 fires, next instr reads r5 -> de_stall=1 until wb_valid r5, fire on following cycle.
REQ-031 SHALL cover: 4 long ops issued, 5th long op -> stalled at inflight_cnt=4; one wb_valid -> 5th fires, cnt stays 4.
REQ-032 SHALL cover: serial op with inflight_cnt=2 -> DRAIN, fires after 2 returns, HOLD until ser_done, then RUN.
REQ-033 SHALL cover: same-cycle wb_valid r7 and long issue to r7 -> sb_busy[7]=1, inflight_cnt unchanged.
REQ-034 SHALL cover: flush in HOLD with 1 long outstanding -> ctl_state=RUN, iss_fire=0, sb_busy and inflight_cnt=1 preserved.
REQ-035 SHALL cover: writes/reads of r0 with long op -> no busy bit, no stall; rst mid-DRAIN -> all state cleared.

Source files
------------

// File: rtl/cpu7_iss_pkg.sv
// -----------------------------------------------------------------------------
// cpu7_iss_pkg
// Shared definitions for the issue-control slice:
//   - iss_state_e    : issue-control FSM encoding seen on ctl_state
//                      (RUN=0, DRAIN=1, HOLD=2)
//   - IFLT_MAX_DEFAULT: default ceiling on outstanding long-latency ops
//   - CNT_W          : width of the in-flight counter
// -----------------------------------------------------------------------------
package cpu7_iss_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,  // normal issue
        ST_DRAIN = 2'd1,  // serial op waiting for long ops to return
        ST_HOLD  = 2'd2   // serial op issued, waiting for it to retire
    } iss_state_e;

    localparam int IFLT_MAX_DEFAULT = 4;
    localparam int CNT_W            = 3;

endpackage

// File: rtl/cpu7_ifu_iss_ctl_if.sv
// -----------------------------------------------------------------------------
// cpu7_ifu_iss_ctl_if
// Signal bundle between the decode/issue stage and the issue controller.
//
// Issue handshake: an instruction is offered while is_valid is high and is
// taken in exactly the cycles where iss_fire is high. iss_fire already folds
// in ex_ready, flush, hazards and the serialization state, so the producer
// must hold the instruction stable until it sees iss_fire (or a flush).
// de_stall tells decode to hold; wb_valid/ser_done are single-cycle pulses.
//
//   master : decode/issue side (drives instruction, execute and writeback info)
//   slave  : issue controller (drives iss_fire, de_stall and status)
// -----------------------------------------------------------------------------
interface cpu7_ifu_iss_ctl_if;

    logic        is_valid;
    logic [4:0]  is_rs1;
    logic [4:0]  is_rs2;
    logic        is_rs1_en;
    logic        is_rs2_en;
    logic        is_rf_wen;
    logic [4:0]  is_rf_target;
    logic        is_long;
    logic        is_serial;
    logic        ex_ready;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rf_target;
    logic        ser_done;

    logic        iss_fire;
    logic        de_stall;
    logic [31:0] sb_busy;
    logic [2:0]  inflight_cnt;
    logic [1:0]  ctl_state;

    modport master (
        output is_valid, is_rs1, is_rs2, is_rs1_en, is_rs2_en,
               is_rf_wen, is_rf_target, is_long, is_serial,
               ex_ready, flush, wb_valid, wb_rf_target, ser_done,
        input  iss_fire, de_stall, sb_busy, inflight_cnt, ctl_state
    );

    modport slave (
        input  is_valid, is_rs1, is_rs2, is_rs1_en, is_rs2_en,
               is_rf_wen, is_rf_target, is_long, is_serial,
               ex_ready, flush, wb_valid, wb_rf_target, ser_done,
        output iss_fire, de_stall, sb_busy, inflight_cnt, ctl_state
    );

endinterface

// File: rtl/cpu7_iss_sb.sv
// -----------------------------------------------------------------------------
// cpu7_iss_sb
// Register scoreboard: one busy bit per architectural register, set when a
// long-latency op that writes a register issues, cleared by its writeback.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   rs1_en_i/rs1_i      source 1 read enable / register
//   rs2_en_i/rs2_i      source 2 read enable / register
//   rf_wen_i/rf_target_i destination write enable / register
//   long_fire_i         a long-latency op issues this cycle
//   wb_valid_i/wb_target_i long-latency writeback return
//   hazard_o            RAW on either source or WAW on destination
//   busy_o              busy vector (bit 0 always 0)
// -----------------------------------------------------------------------------
module cpu7_iss_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs1_en_i,
    input  logic [4:0]  rs1_i,
    input  logic        rs2_en_i,
    input  logic [4:0]  rs2_i,
    input  logic        rf_wen_i,
    input  logic [4:0]  rf_target_i,
    input  logic        long_fire_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_target_i,
    output logic        hazard_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        raw1;
    logic        raw2;
    logic        waw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Clear is applied first so a same-cycle set of the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) begin
            busy_d[wb_target_i] = 1'b0;
        end
        if (long_fire_i && rf_wen_i && (rf_target_i != 5'd0)) begin
            busy_d[rf_target_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Lookup uses the registered vector only; a writeback in the same cycle
    // does not bypass, so the consumer issues one cycle after the return.
    always_comb begin
        raw1     = rs1_en_i && (rs1_i != 5'd0) && busy_q[rs1_i];
        raw2     = rs2_en_i && (rs2_i != 5'd0) && busy_q[rs2_i];
        waw      = rf_wen_i && (rf_target_i != 5'd0) && busy_q[rf_target_i];
        hazard_o = raw1 || raw2 || waw;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/cpu7_ifu_iss_ctl.sv
// -----------------------------------------------------------------------------
// cpu7_ifu_iss_ctl
// Issue controller: decides each cycle whether the instruction at issue fires,
// tracks outstanding long-latency ops and serializes CSR/syscall-class ops.
//
// Ports:
//   clk  pipeline clock
//   rst  asynchronous active-high reset
//   bus  cpu7_ifu_iss_ctl_if.slave:
//          in : is_valid, is_rs1/2(_en), is_rf_wen, is_rf_target, is_long,
//               is_serial, ex_ready, flush, wb_valid, wb_rf_target, ser_done
//          out: iss_fire, de_stall, sb_busy[31:0], inflight_cnt[2:0],
//               ctl_state[1:0] (FSM state, RUN/DRAIN/HOLD)
// Parameter:
//   IFLT_MAX  maximum outstanding long-latency ops (<= 7)
// -----------------------------------------------------------------------------
module cpu7_ifu_iss_ctl
    import cpu7_iss_pkg::*;
#(
    parameter int IFLT_MAX = IFLT_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    cpu7_ifu_iss_ctl_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IFLT_MAX);

    iss_state_e        state_q;
    iss_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              hazard;
    logic              permit;
    logic              fire;
    logic              cnt_zero;
    logic              cnt_full;
    logic              cnt_inc;
    logic              cnt_dec;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_full = (cnt_q == CNT_MAX);

    cpu7_iss_sb u_sb (
        .clk         (clk),
        .rst         (rst),
        .rs1_en_i    (bus.is_rs1_en),
        .rs1_i       (bus.is_rs1),
        .rs2_en_i    (bus.is_rs2_en),
        .rs2_i       (bus.is_rs2),
        .rf_wen_i    (bus.is_rf_wen),
        .rf_target_i (bus.is_rf_target),
        .long_fire_i (fire && bus.is_long),
        .wb_valid_i  (bus.wb_valid),
        .wb_target_i (bus.wb_rf_target),
        .hazard_o    (hazard),
        .busy_o      (bus.sb_busy)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions look at is_valid/fire but never ex_ready directly, so a
    // serial op enters DRAIN even while execute is busy.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.is_valid && bus.is_serial && !cnt_zero) begin
                        state_d = ST_DRAIN;
                    end else if (fire && bus.is_serial) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (fire) begin
                        state_d = bus.is_serial ? ST_HOLD : ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (bus.ser_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Serial ops in RUN need an empty pipe; DRAIN opens only once empty.
    always_comb begin
        permit        = 1'b0;
        bus.ctl_state = state_q;
        case (state_q)
            ST_RUN:   permit = !bus.is_serial || cnt_zero;
            ST_DRAIN: permit = cnt_zero;
            ST_HOLD:  permit = 1'b0;
            default:  permit = 1'b0;
        endcase
    end

    // --------------------------------------------------------- issue logic
    always_comb begin
        fire = bus.is_valid && bus.ex_ready && !bus.flush && !hazard &&
               permit && !(bus.is_long && cnt_full);
        bus.iss_fire = fire;
        bus.de_stall = bus.is_valid && !fire && !bus.flush;
    end

    // ---------------------------------------------------- in-flight count
    // A return with nothing outstanding is dropped rather than wrapping.
    always_comb begin
        cnt_inc = fire && bus.is_long;
        cnt_dec = bus.wb_valid && !cnt_zero;
        cnt_d   = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.inflight_cnt = cnt_q;

endmodule

// File: tb/tb_cpu7_ifu_iss_ctl.sv
module tb_cpu7_ifu_iss_ctl;
    import cpu7_iss_pkg::*;

    localparam int IFLT = 4;

    // ------------------------------------------------ clock / reset block
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu7_ifu_iss_ctl_if bus ();

    cpu7_ifu_iss_ctl #(.IFLT_MAX(IFLT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------ reference model
    bit [31:0] busy_m;   // registers with an outstanding long write
    int        cnt_m;    // number of long ops in flight
    int        mode_m;   // 0 normal, 1 waiting to drain, 2 serial op in flight

    function automatic void m_reset();
        busy_m = '0;
        cnt_m  = 0;
        mode_m = 0;
    endfunction

    function automatic bit m_fire();
        bit blocked = 1'b0;
        bit allowed;
        if (bus.is_rs1_en && bus.is_rs1 != 0 && busy_m[bus.is_rs1]) blocked = 1'b1;
        if (bus.is_rs2_en && bus.is_rs2 != 0 && busy_m[bus.is_rs2]) blocked = 1'b1;
        if (bus.is_rf_wen && bus.is_rf_target != 0 && busy_m[bus.is_rf_target]) blocked = 1'b1;
        if (mode_m == 0)      allowed = !bus.is_serial || cnt_m == 0;
        else if (mode_m == 1) allowed = (cnt_m == 0);
        else                  allowed = 1'b0;
        if (bus.is_long && cnt_m >= IFLT) allowed = 1'b0;
        return bus.is_valid && bus.ex_ready && !bus.flush && !blocked && allowed;
    endfunction

    function automatic void m_advance();
        bit f       = m_fire();
        int old_cnt = cnt_m;
        if (bus.wb_valid) busy_m[bus.wb_rf_target] = 1'b0;
        if (f && bus.is_long && bus.is_rf_wen && bus.is_rf_target != 0)
            busy_m[bus.is_rf_target] = 1'b1;
        if (f && bus.is_long) cnt_m = cnt_m + 1;
        if (bus.wb_valid && old_cnt > 0) cnt_m = cnt_m - 1;
        if (bus.flush) mode_m = 0;
        else if (mode_m == 0) begin
            if (bus.is_valid && bus.is_serial && old_cnt != 0) mode_m = 1;
            else if (f && bus.is_serial) mode_m = 2;
        end else if (mode_m == 1) begin
            if (f) mode_m = bus.is_serial ? 2 : 0;
        end else if (bus.ser_done) mode_m = 0;
    endfunction

    // ------------------------------------------------ driver tasks
    task automatic set_idle();
        bus.is_valid = 0; bus.is_rs1 = 0; bus.is_rs2 = 0;
        bus.is_rs1_en = 0; bus.is_rs2_en = 0; bus.is_rf_wen = 0;
        bus.is_rf_target = 0; bus.is_long = 0; bus.is_serial = 0;
        bus.ex_ready = 1; bus.flush = 0; bus.wb_valid = 0;
        bus.wb_rf_target = 0; bus.ser_done = 0;
    endtask

    task automatic set_instr(input bit lng, input bit ser, input bit wen,
                             input logic [4:0] tgt, input bit en1,
                             input logic [4:0] r1, input bit en2,
                             input logic [4:0] r2);
        bus.is_valid = 1; bus.is_long = lng; bus.is_serial = ser;
        bus.is_rf_wen = wen; bus.is_rf_target = tgt;
        bus.is_rs1_en = en1; bus.is_rs1 = r1;
        bus.is_rs2_en = en2; bus.is_rs2 = r2;
    endtask

    // Advance model and DUT by one clock; returns #1 after the edge.
    task automatic tick();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------ tests
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #3;
        checks++; if (bus.sb_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.sb_busy); end
        checks++; if (bus.inflight_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.inflight_cnt); end
        checks++; if (bus.ctl_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.ctl_state); end
        set_instr(0, 0, 1, 5'd3, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL reset_comb_fire: got %b want 1", bus.iss_fire); end
        set_idle();
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_raw_stall();
        set_instr(1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL raw_long_fire: got %b want 1", bus.iss_fire); end
        tick();
        checks++; if (bus.sb_busy !== 32'h20) begin errors++; $display("FAIL raw_busy5: got %h want 00000020", bus.sb_busy); end
        set_instr(0, 0, 1, 5'd6, 1, 5'd5, 0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.de_stall !== 1'b1 || bus.iss_fire !== 1'b0) begin errors++; $display("FAIL raw_stall: got stall=%b fire=%b want 1/0", bus.de_stall, bus.iss_fire); end
            tick();
        end
        bus.wb_valid = 1; bus.wb_rf_target = 5'd5;
        #1;
        checks++; if (bus.de_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_wb_cycle: got %b want 1", bus.de_stall); end
        tick();
        bus.wb_valid = 0;
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL raw_fire_after_wb: got %b want 1", bus.iss_fire); end
        tick();
        set_idle();
        checks++; if (bus.sb_busy !== 32'h0 || bus.inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_clean: got busy=%h cnt=%0d want 0/0", bus.sb_busy, bus.inflight_cnt); end
    endtask

    task automatic test_inflight_limit();
        for (int i = 0; i < 4; i++) begin
            set_instr(1, 0, 1, 5'(10 + i), 0, 5'd0, 0, 5'd0);
            #1;
            checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL lim_fire%0d: got %b want 1", i, bus.iss_fire); end
            tick();
        end
        checks++; if (bus.inflight_cnt !== 3'd4) begin errors++; $display("FAIL lim_cnt4: got %0d want 4", bus.inflight_cnt); end
        set_instr(1, 0, 1, 5'd14, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b0 || bus.de_stall !== 1'b1) begin errors++; $display("FAIL lim_5th_stall: got fire=%b stall=%b want 0/1", bus.iss_fire, bus.de_stall); end
        tick();
        bus.wb_valid = 1; bus.wb_rf_target = 5'd10;
        #1;
        checks++; if (bus.iss_fire !== 1'b0) begin errors++; $display("FAIL lim_wb_cycle: got %b want 0", bus.iss_fire); end
        tick();
        bus.wb_valid = 0;
        checks++; if (bus.inflight_cnt !== 3'd3) begin errors++; $display("FAIL lim_cnt3: got %0d want 3", bus.inflight_cnt); end
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL lim_5th_fire: got %b want 1", bus.iss_fire); end
        tick();
        checks++; if (bus.inflight_cnt !== 3'd4 || bus.sb_busy !== 32'h0000_7800) begin errors++; $display("FAIL lim_after: got cnt=%0d busy=%h want 4/00007800", bus.inflight_cnt, bus.sb_busy); end
        set_idle();
        for (int t = 11; t <= 14; t++) begin
            bus.wb_valid = 1; bus.wb_rf_target = 5'(t);
            tick();
        end
        bus.wb_valid = 0;
        checks++; if (bus.inflight_cnt !== 3'd0 || bus.sb_busy !== 32'h0) begin errors++; $display("FAIL lim_drain: got cnt=%0d busy=%h want 0/0", bus.inflight_cnt, bus.sb_busy); end
    endtask

    task automatic test_serial_drain();
        set_instr(1, 0, 1, 5'd1, 0, 5'd0, 0, 5'd0); tick();
        set_instr(1, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0); tick();
        checks++; if (bus.inflight_cnt !== 3'd2) begin errors++; $display("FAIL ser_cnt2: got %0d want 2", bus.inflight_cnt); end
        set_instr(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b0 || bus.de_stall !== 1'b1) begin errors++; $display("FAIL ser_nofire: got fire=%b stall=%b want 0/1", bus.iss_fire, bus.de_stall); end
        tick();
        checks++; if (bus.ctl_state !== 2'd1) begin errors++; $display("FAIL ser_drain: got %0d want 1", bus.ctl_state); end
        bus.wb_valid = 1; bus.wb_rf_target = 5'd1;
        #1;
        checks++; if (bus.iss_fire !== 1'b0) begin errors++; $display("FAIL ser_drain_wb1: got %b want 0", bus.iss_fire); end
        tick();
        bus.wb_rf_target = 5'd2;
        #1;
        checks++; if (bus.iss_fire !== 1'b0) begin errors++; $display("FAIL ser_drain_wb2: got %b want 0", bus.iss_fire); end
        tick();
        bus.wb_valid = 0;
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL ser_fire: got %b want 1", bus.iss_fire); end
        tick();
        checks++; if (bus.ctl_state !== 2'd2) begin errors++; $display("FAIL ser_hold: got %0d want 2", bus.ctl_state); end
        set_instr(0, 0, 1, 5'd3, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b0 || bus.de_stall !== 1'b1) begin errors++; $display("FAIL ser_hold_block: got fire=%b stall=%b want 0/1", bus.iss_fire, bus.de_stall); end
        tick();
        bus.ser_done = 1;
        tick();
        bus.ser_done = 0;
        checks++; if (bus.ctl_state !== 2'd0) begin errors++; $display("FAIL ser_run: got %0d want 0", bus.ctl_state); end
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL ser_run_fire: got %b want 1", bus.iss_fire); end
        tick();
        set_idle();
    endtask

    task automatic test_same_cycle_set_clear();
        set_instr(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
        set_instr(1, 0, 1, 5'd7, 0, 5'd0, 0, 5'd0);
        bus.wb_valid = 1; bus.wb_rf_target = 5'd7;
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL sc_fire: got %b want 1", bus.iss_fire); end
        tick();
        set_idle();
        checks++; if (bus.sb_busy !== 32'h80 || bus.inflight_cnt !== 3'd1) begin errors++; $display("FAIL sc_set_wins: got busy=%h cnt=%0d want 00000080/1", bus.sb_busy, bus.inflight_cnt); end
        bus.wb_valid = 1; bus.wb_rf_target = 5'd7; tick();
        bus.wb_valid = 0;
    endtask

    task automatic test_flush_hold();
        set_instr(1, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0);
        tick();
        checks++; if (bus.ctl_state !== 2'd2 || bus.inflight_cnt !== 3'd1) begin errors++; $display("FAIL fl_setup: got state=%0d cnt=%0d want 2/1", bus.ctl_state, bus.inflight_cnt); end
        set_instr(0, 0, 1, 5'd3, 0, 5'd0, 0, 5'd0);
        bus.flush = 1; bus.ser_done = 1;
        #1;
        checks++; if (bus.iss_fire !== 1'b0 || bus.de_stall !== 1'b0) begin errors++; $display("FAIL fl_suppress: got fire=%b stall=%b want 0/0", bus.iss_fire, bus.de_stall); end
        tick();
        bus.flush = 0; bus.ser_done = 0;
        checks++; if (bus.ctl_state !== 2'd0 || bus.inflight_cnt !== 3'd1 || bus.sb_busy !== 32'h200) begin errors++; $display("FAIL fl_keep: got state=%0d cnt=%0d busy=%h want 0/1/00000200", bus.ctl_state, bus.inflight_cnt, bus.sb_busy); end
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL fl_after_fire: got %b want 1", bus.iss_fire); end
        tick();
        set_idle();
        bus.wb_valid = 1; bus.wb_rf_target = 5'd9; tick();
        bus.wb_valid = 0;
    endtask

    task automatic test_r0_and_underflow();
        set_instr(1, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL r0_fire: got %b want 1", bus.iss_fire); end
        tick();
        checks++; if (bus.sb_busy !== 32'h0 || bus.inflight_cnt !== 3'd1) begin errors++; $display("FAIL r0_nobusy: got busy=%h cnt=%0d want 0/1", bus.sb_busy, bus.inflight_cnt); end
        set_instr(0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
        #1;
        checks++; if (bus.iss_fire !== 1'b1 || bus.de_stall !== 1'b0) begin errors++; $display("FAIL r0_read: got fire=%b stall=%b want 1/0", bus.iss_fire, bus.de_stall); end
        tick();
        set_idle();
        bus.wb_valid = 1; bus.wb_rf_target = 5'd0; tick();
        tick();
        bus.wb_valid = 0;
        checks++; if (bus.inflight_cnt !== 3'd0) begin errors++; $display("FAIL underflow: got %0d want 0", bus.inflight_cnt); end
    endtask

    task automatic test_reset_mid_drain();
        set_instr(1, 0, 1, 5'd4, 0, 5'd0, 0, 5'd0); tick();
        set_instr(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
        checks++; if (bus.ctl_state !== 2'd1) begin errors++; $display("FAIL rd_drain: got %0d want 1", bus.ctl_state); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.ctl_state !== 2'd0 || bus.inflight_cnt !== 3'd0 || bus.sb_busy !== 32'h0) begin errors++; $display("FAIL rd_cleared: got state=%0d cnt=%0d busy=%h want 0/0/0", bus.ctl_state, bus.inflight_cnt, bus.sb_busy); end
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.iss_fire !== 1'b1) begin errors++; $display("FAIL rd_serial_fires: got %b want 1", bus.iss_fire); end
        set_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.is_valid     = ($urandom_range(0, 3) != 0);
            bus.is_rs1       = 5'($urandom_range(0, 7));
            bus.is_rs2       = 5'($urandom_range(0, 7));
            bus.is_rs1_en    = ($urandom_range(0, 1) != 0);
            bus.is_rs2_en    = ($urandom_range(0, 1) != 0);
            bus.is_rf_wen    = ($urandom_range(0, 3) != 0);
            bus.is_rf_target = 5'($urandom_range(0, 7));
            bus.is_long      = ($urandom_range(0, 1) != 0);
            bus.is_serial    = ($urandom_range(0, 9) == 0);
            bus.ex_ready     = ($urandom_range(0, 4) != 0);
            bus.flush        = ($urandom_range(0, 19) == 0);
            bus.wb_valid     = ($urandom_range(0, 2) == 0);
            bus.wb_rf_target = 5'($urandom_range(0, 7));
            bus.ser_done     = ($urandom_range(0, 3) == 0);
            #1;
            checks++; if (bus.iss_fire !== m_fire()) begin errors++; $display("FAIL rnd_fire[%0d]: got %b want %b", n, bus.iss_fire, m_fire()); end
            checks++; if (bus.de_stall !== (bus.is_valid && !m_fire() && !bus.flush)) begin errors++; $display("FAIL rnd_stall[%0d]: got %b", n, bus.de_stall); end
            tick();
            checks++; if (bus.sb_busy !== busy_m) begin errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, bus.sb_busy, busy_m); end
            checks++; if (bus.inflight_cnt !== 3'(cnt_m)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, bus.inflight_cnt, cnt_m); end
            checks++; if (bus.ctl_state !== 2'(mode_m)) begin errors++; $display("FAIL rnd_state[%0d]: got %0d want %0d", n, bus.ctl_state, mode_m); end
        end
        set_idle();
    endtask

    // ------------------------------------------------ sequence + report
    initial begin
        m_reset();
        test_reset();
        test_raw_stall();
        test_inflight_limit();
        test_serial_drain();
        test_same_cycle_set_clear();
        test_flush_hold();
        test_r0_and_underflow();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
